// File: rtl/phy_ctl_pkg.sv
// rtl/phy_ctl_pkg.sv - shared op codes, control-word field layout and FSM states
package phy_ctl_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_WR  = 3'd1,
        OP_RD  = 3'd3,
        OP_ACT = 3'd4,
        OP_PRE = 3'd5,
        OP_REF = 3'd6
    } op_e;

    localparam int WD_W     = 32;
    localparam int OP_LSB   = 0;
    localparam int OP_W     = 3;
    localparam int OFS_LSB  = 3;
    localparam int OFS_W    = 6;
    localparam int RANK_LSB = 9;
    localparam int RANK_W   = 2;
    localparam int AUX_LSB  = 11;
    localparam int AUX_W    = 4;
    localparam int SEQ_LSB  = 15;
    localparam int SEQ_W    = 2;

    typedef enum logic [1:0] {
        ST_WAIT_RDY = 2'd0,
        ST_RUN      = 2'd1,
        ST_HOLD     = 2'd2
    } state_e;

    // Bits above the seq field are always zero.
    function automatic logic [WD_W-1:0] pack_word(
        input logic [OP_W-1:0]   op,
        input logic [OFS_W-1:0]  ofs,
        input logic [RANK_W-1:0] rank,
        input logic [AUX_W-1:0]  aux,
        input logic [SEQ_W-1:0]  seq
    );
        logic [WD_W-1:0] w;
        w = '0;
        w[OP_LSB   +: OP_W]   = op;
        w[OFS_LSB  +: OFS_W]  = ofs;
        w[RANK_LSB +: RANK_W] = rank;
        w[AUX_LSB  +: AUX_W]  = aux;
        w[SEQ_LSB  +: SEQ_W]  = seq;
        return w;
    endfunction

endpackage

// File: rtl/phy_ctl_cmd_fifo.sv
// rtl/phy_ctl_cmd_fifo.sv - DEPTH x WIDTH synchronous FIFO with full/empty flags
module phy_ctl_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/phy_ctl_cmd_writer.sv
// rtl/phy_ctl_cmd_writer.sv - packs scheduler commands into PHY control words and issues them under PHY flow control
module phy_ctl_cmd_writer #(
    parameter int DEPTH        = 4,
    parameter int READY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_rank,
    input  logic [5:0]  cmd_data_offset,
    input  logic [3:0]  cmd_aux,
    input  logic        phy_ctl_ready,
    input  logic        phy_ctl_almost_full,
    input  logic        phy_ctl_full,
    output logic [31:0] phy_ctl_wd,
    output logic        phy_ctl_wr_en,
    output logic [15:0] issued_cnt,
    output logic        overflow_err
);

    import phy_ctl_pkg::*;

    localparam int          RW       = $clog2(READY_CYCLES + 1);
    localparam logic [RW-1:0] RDY_LAST = RW'(READY_CYCLES - 1);

    state_e            state_q, state_d;
    logic [RW-1:0]     rdy_cnt_q, rdy_cnt_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              wr_en_q, wr_en_d;
    logic [15:0]       issued_q, issued_d;
    logic              ovf_q, ovf_d;

    logic              push;
    logic              issue;
    logic [WD_W-1:0]   push_word;
    logic [WD_W-1:0]   fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    assign cmd_ready     = !fifo_full && !rst;
    assign push_word     = pack_word(cmd_op, cmd_data_offset, cmd_rank, cmd_aux, seq_q);
    assign phy_ctl_wd    = wd_q;
    assign phy_ctl_wr_en = wr_en_q;
    assign issued_cnt    = issued_q;
    assign overflow_err  = ovf_q;

    phy_ctl_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_word),
        .pop   (issue),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready loss wins over almost-full; queued words are kept across state changes.
    always_comb begin
        state_d   = state_q;
        rdy_cnt_d = rdy_cnt_q;
        case (state_q)
            ST_WAIT_RDY: begin
                if (!phy_ctl_ready) begin
                    rdy_cnt_d = '0;
                end else if (rdy_cnt_q == RDY_LAST) begin
                    rdy_cnt_d = '0;
                    state_d   = ST_RUN;
                end else begin
                    rdy_cnt_d = rdy_cnt_q + RW'(1);
                end
            end
            ST_RUN: begin
                if (!phy_ctl_ready) begin
                    state_d = ST_WAIT_RDY;
                end else if (phy_ctl_almost_full) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!phy_ctl_ready) begin
                    state_d = ST_WAIT_RDY;
                end else if (!phy_ctl_almost_full) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_WAIT_RDY;
                rdy_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        push     = cmd_valid && cmd_ready;
        issue    = (state_q == ST_RUN) && !fifo_empty &&
                   !phy_ctl_almost_full && !phy_ctl_full;
        seq_d    = push ? seq_q + SEQ_W'(1) : seq_q;
        wr_en_d  = issue;
        wd_d     = issue ? fifo_dout : wd_q;
        issued_d = (wr_en_q && (issued_q != 16'hFFFF)) ? issued_q + 16'd1 : issued_q;
        // A write presented while the PHY reports full is a lost word.
        ovf_d    = ovf_q || (wr_en_q && phy_ctl_full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_RDY;
            rdy_cnt_q <= '0;
            seq_q     <= '0;
            wd_q      <= '0;
            wr_en_q   <= 1'b0;
            issued_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_cnt_q <= rdy_cnt_d;
            seq_q     <= seq_d;
            wd_q      <= wd_d;
            wr_en_q   <= wr_en_d;
            issued_q  <= issued_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_phy_ctl_cmd_writer.sv
// tb/tb_phy_ctl_cmd_writer.sv - self-checking bench for phy_ctl_cmd_writer
module tb_phy_ctl_cmd_writer;

    localparam int DEPTH        = 4;
    localparam int READY_CYCLES = 2;
    localparam int M_WAIT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_rank;
    logic [5:0]  cmd_data_offset;
    logic [3:0]  cmd_aux;
    logic        phy_ctl_ready;
    logic        phy_ctl_almost_full;
    logic        phy_ctl_full;
    logic [31:0] phy_ctl_wd;
    logic        phy_ctl_wr_en;
    logic [15:0] issued_cnt;
    logic        overflow_err;

    phy_ctl_cmd_writer #(
        .DEPTH        (DEPTH),
        .READY_CYCLES (READY_CYCLES)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_op              (cmd_op),
        .cmd_rank            (cmd_rank),
        .cmd_data_offset     (cmd_data_offset),
        .cmd_aux             (cmd_aux),
        .phy_ctl_ready       (phy_ctl_ready),
        .phy_ctl_almost_full (phy_ctl_almost_full),
        .phy_ctl_full        (phy_ctl_full),
        .phy_ctl_wd          (phy_ctl_wd),
        .phy_ctl_wr_en       (phy_ctl_wr_en),
        .issued_cnt          (issued_cnt),
        .overflow_err        (overflow_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    logic [31:0] got [$];
    int          got_cyc [$];

    // Reference model state
    logic [31:0] mq [$];
    int          m_seq = 0;
    int          m_mode = M_WAIT;
    int          m_streak = 0;
    logic [31:0] m_wd = '0;
    logic        m_wr = 1'b0;
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk(input int op, input int ofs, input int rank,
                                       input int aux, input int seq);
        return 32'(op + ofs * 8 + rank * 512 + aux * 2048 + seq * 32768);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        logic acc;
        logic iss;
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_seq = 0; m_mode = M_WAIT; m_streak = 0;
            m_wd = '0; m_wr = 1'b0; m_cnt = 0; m_ovf = 1'b0;
        end else begin
            acc = cmd_valid && (mq.size() < DEPTH);
            iss = (m_mode == M_RUN) && (mq.size() > 0) && !phy_ctl_almost_full && !phy_ctl_full;
            if (m_wr && m_cnt < 65535) m_cnt++;
            if (m_wr && phy_ctl_full) m_ovf = 1'b1;
            m_wr = iss;
            if (iss) m_wd = mq.pop_front();
            if (acc) begin
                mq.push_back(mk(int'(cmd_op), int'(cmd_data_offset), int'(cmd_rank),
                                int'(cmd_aux), m_seq));
                m_seq = (m_seq + 1) % 4;
            end
            if (m_mode == M_WAIT) begin
                m_streak = phy_ctl_ready ? m_streak + 1 : 0;
                if (m_streak == READY_CYCLES) begin
                    m_mode = M_RUN;
                    m_streak = 0;
                end
            end else if (!phy_ctl_ready) begin
                m_mode = M_WAIT;
            end else if (m_mode == M_RUN && phy_ctl_almost_full) begin
                m_mode = M_HOLD;
            end else if (m_mode == M_HOLD && !phy_ctl_almost_full) begin
                m_mode = M_RUN;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (chk_en && !rst) begin
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, mq.size() < DEPTH});
            chk("wr_en", {31'd0, phy_ctl_wr_en}, {31'd0, m_wr});
            chk("wd", phy_ctl_wd, m_wd);
            chk("issued_cnt", {16'd0, issued_cnt}, 32'(m_cnt));
            chk("overflow_err", {31'd0, overflow_err}, {31'd0, m_ovf});
            if (phy_ctl_wr_en) begin
                got.push_back(phy_ctl_wd);
                got_cyc.push_back(cyc);
            end
        end
    end

    task automatic push(input int op, input int ofs, input int rank, input int aux);
        logic acc;
        acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 3'(op);
        cmd_data_offset = 6'(ofs);
        cmd_rank = 2'(rank);
        cmd_aux = 4'(aux);
        for (int t = 0; t < 300 && !acc; t++) begin
            acc = cmd_ready;
            @(negedge clk);
        end
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, input string name);
        int t;
        t = 0;
        while (got.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(got.size()), 32'(n));
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        #2 rst = 1'b1;
        phy_ctl_ready = rdy;
        phy_ctl_almost_full = 1'b0;
        phy_ctl_full = 1'b0;
        cmd_valid = 1'b0;
        #4 rst = 1'b0;
        got.delete();
        got_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_rank = '0; cmd_data_offset = '0; cmd_aux = '0;
        phy_ctl_ready = 1'b0; phy_ctl_almost_full = 1'b0; phy_ctl_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_wd", phy_ctl_wd, 32'd0);
        chk("rst_wr_en", {31'd0, phy_ctl_wr_en}, 32'd0);
        chk("rst_issued", {16'd0, issued_cnt}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
        phy_ctl_ready = 1'b1;
        #6 rst = 1'b0;
        chk_en = 1'b1;

        // Single command: WR, offset 5, rank 1, aux 0xA, seq 0
        push(1, 5, 1, 10);
        wait_got(1, "t1_count");
        chk("t1_word", got[0], 32'h0000_5229);
        repeat (2) @(negedge clk);
        chk("t1_issued", {16'd0, issued_cnt}, 32'd1);

        // Queue fills with PHY not ready, then drains back-to-back
        do_reset(1'b0);
        fork
            begin
                for (int i = 0; i < 5; i++) push(3, i + 1, i % 4, i);
            end
            begin
                repeat (12) @(negedge clk);
                chk("t2_ready_low", {31'd0, cmd_ready}, 32'd0);
                chk("t2_no_issue", 32'(got.size()), 32'd0);
                phy_ctl_ready = 1'b1;
            end
        join
        wait_got(5, "t2_count");
        chk("t2_first", got[0], 32'h0000_000B);
        chk("t2_fifth", got[4], 32'h0000_202B);
        for (int k = 0; k < 5; k++) chk("t2_seq", 32'(got[k][16:15]), 32'(k % 4));
        chk("t2_b2b", 32'(got_cyc[4] - got_cyc[0]), 32'd4);
        repeat (2) @(negedge clk);
        chk("t2_issued", {16'd0, issued_cnt}, 32'd5);

        // Streaming with an almost-full hold window
        do_reset(1'b1);
        fork
            begin
                for (int i = 0; i < 8; i++) push(1, i, i % 4, 15 - i);
            end
            begin
                int t;
                t = 0;
                while (got.size() < 2 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                phy_ctl_almost_full = 1'b1;
                repeat (3) @(negedge clk);
                phy_ctl_almost_full = 1'b0;
            end
        join
        wait_got(8, "t3_count");
        for (int k = 0; k < 8; k++) chk("t3_order", got[k], mk(1, k, k % 4, 15 - k, k % 4));
        chk("t3_gap", {31'd0, (got_cyc[7] - got_cyc[0]) > 7}, 32'd1);

        // Full asserted while a write strobe is out
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        fork
            begin
                push(1, 1, 0, 0);
                push(1, 2, 0, 0);
            end
            begin
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (phy_ctl_wr_en) break;
                end
                phy_ctl_full = 1'b1;
                @(negedge clk);
                phy_ctl_full = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        chk("t4_ovf_set", {31'd0, overflow_err}, 32'd1);
        repeat (6) @(negedge clk);
        chk("t4_ovf_sticky", {31'd0, overflow_err}, 32'd1);

        // Ready dropped in RUN with three queued words
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        phy_ctl_full = 1'b1;
        for (int k = 0; k < 3; k++) push(5, k + 2, 2, k);
        phy_ctl_ready = 1'b0;
        @(negedge clk);
        phy_ctl_full = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5_stalled", 32'(got.size()), 32'd0);
        chk("t5_no_ovf", {31'd0, overflow_err}, 32'd0);
        phy_ctl_ready = 1'b1;
        wait_got(3, "t5_count");
        chk("t5_first", got[0], 32'h0000_0415);
        for (int k = 0; k < 3; k++) chk("t5_order", got[k], mk(5, k + 2, 2, k, k));
        chk("t5_b2b", 32'(got_cyc[2] - got_cyc[0]), 32'd2);

        // Asynchronous reset mid-stream
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) push(4, k, 3, 1);
        for (int t = 0; t < 50 && !phy_ctl_wr_en; t++) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_wd", phy_ctl_wd, 32'd0);
        chk("t6_wr_en", {31'd0, phy_ctl_wr_en}, 32'd0);
        chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("t6_issued", {16'd0, issued_cnt}, 32'd0);
        chk("t6_ovf", {31'd0, overflow_err}, 32'd0);
        #2 rst = 1'b0;
        got.delete();
        got_cyc.delete();
        push(6, 0, 0, 0);
        wait_got(1, "t6_count");
        chk("t6_seq0", 32'(got[0][16:15]), 32'd0);
        chk("t6_word", got[0], 32'h0000_0006);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
